// File: rtl/demux_slot_scheduler.sv
// Round-robin time-slot scheduler for a 1-to-4 demux.
// Four consumers share one data line. Each grant lasts at most
// SLOT_CYCLES cycles and ends early if its requester lets go.
// Every grant is followed by a one-cycle gap with the data line gated
// off and the select held, then one idle cycle before the next grant.
module demux_slot_scheduler #(
    parameter int SLOT_CYCLES = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_req,
    input  logic       i_data,
    output logic       o_sel_1,
    output logic       o_sel_2,
    output logic       o_data,
    output logic [3:0] o_grant,
    output logic       o_busy
);

    localparam int              CNT_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       g;
    logic [1:0]       last_g;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       grant_q;
    logic             busy_q;

    logic [1:0]       pick_idx;
    logic             pick_valid;
    logic [1:0]       cand;

    // Find the first requester after the last served one, wrapping around
    always_comb begin
        pick_idx   = 2'd0;
        pick_valid = 1'b0;
        cand       = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_g + 2'(i);
            if (!pick_valid && i_req[cand]) begin
                pick_idx   = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Scheduler state machine; the select (g) is only changed on a new grant
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            g       <= 2'd0;
            last_g  <= 2'd3;
            cnt     <= '0;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        g       <= pick_idx;
                        cnt     <= '0;
                        grant_q <= 4'b0001 << pick_idx;
                        busy_q  <= 1'b1;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!i_req[g] || (cnt == CNT_LAST)) begin
                        grant_q <= 4'b0000;
                        busy_q  <= 1'b0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    last_g <= g;
                    state  <= IDLE;
                end
                default: begin
                    grant_q <= 4'b0000;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Select follows the held grant index; data is gated by the registered busy
    always_comb begin
        o_sel_1 = g[1];
        o_sel_2 = g[0];
        o_grant = grant_q;
        o_busy  = busy_q;
        o_data  = i_data & busy_q;
    end

endmodule

// File: tb/tb_demux_slot_scheduler.sv
// Directed testbench for demux_slot_scheduler.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_demux_slot_scheduler;

    logic       i_clk;
    logic       i_reset;
    logic [3:0] i_req;
    logic       i_data;
    logic       o_sel_1;
    logic       o_sel_2;
    logic       o_data;
    logic [3:0] o_grant;
    logic       o_busy;

    logic       s1_sel_1;
    logic       s1_sel_2;
    logic       s1_data;
    logic [3:0] s1_grant;
    logic       s1_busy;

    int checks;
    int errors;

    demux_slot_scheduler #(.SLOT_CYCLES(8)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_req   (i_req),
        .i_data  (i_data),
        .o_sel_1 (o_sel_1),
        .o_sel_2 (o_sel_2),
        .o_data  (o_data),
        .o_grant (o_grant),
        .o_busy  (o_busy)
    );

    demux_slot_scheduler #(.SLOT_CYCLES(1)) dut_s1 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_req   (i_req),
        .i_data  (i_data),
        .o_sel_1 (s1_sel_1),
        .o_sel_2 (s1_sel_2),
        .o_data  (s1_data),
        .o_grant (s1_grant),
        .o_busy  (s1_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Two reset cycles with no requests; returns on a falling edge with reset low
    task automatic do_reset();
        i_reset = 1'b1;
        i_req   = 4'b0000;
        i_data  = 1'b0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_req   = 4'b1111;
        i_data  = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge i_clk);
            checks++;
            if (o_grant !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset_grant: got %b expected %b", o_grant, 4'b0000);
            end
            checks++;
            if (o_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_busy: got %b expected %b", o_busy, 1'b0);
            end
            checks++;
            if ({o_sel_1, o_sel_2} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_sel: got %b expected %b", {o_sel_1, o_sel_2}, 2'b00);
            end
            checks++;
            if (o_data !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_data: got %b expected %b", o_data, 1'b0);
            end
        end
        i_reset = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_grant !== 4'b0001 || {o_sel_1, o_sel_2} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_first_grant: got grant %b sel %b expected grant 0001 sel 00",
                     o_grant, {o_sel_1, o_sel_2});
        end
    endtask

    task automatic test_single_held();
        do_reset();
        i_req = 4'b0100;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 10; c++) begin
                logic [3:0] exp_grant;
                exp_grant = (c < 8) ? 4'b0100 : 4'b0000;
                @(negedge i_clk);
                checks++;
                if (o_grant !== exp_grant || o_busy !== (c < 8) || {o_sel_1, o_sel_2} !== 2'b10) begin
                    errors++;
                    $display("[TB] FAIL single_held r%0d c%0d: got grant %b busy %b sel %b expected grant %b busy %b sel 10",
                             r, c, o_grant, o_busy, {o_sel_1, o_sel_2}, exp_grant, (c < 8));
                end
            end
        end
    endtask

    task automatic test_all_held();
        do_reset();
        i_req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            logic [1:0] idx;
            logic [3:0] one_hot;
            idx     = 2'(r % 4);
            one_hot = 4'b0001 << idx;
            for (int c = 0; c < 10; c++) begin
                logic [3:0] exp_grant;
                exp_grant = (c < 8) ? one_hot : 4'b0000;
                @(negedge i_clk);
                checks++;
                if (o_grant !== exp_grant || {o_sel_1, o_sel_2} !== idx) begin
                    errors++;
                    $display("[TB] FAIL all_held r%0d c%0d: got grant %b sel %b expected grant %b sel %b",
                             r, c, o_grant, {o_sel_1, o_sel_2}, exp_grant, idx);
                end
            end
        end
    endtask

    task automatic test_early_release();
        int busy_count;
        busy_count = 0;
        do_reset();
        i_req = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            if (o_busy === 1'b1) busy_count++;
            checks++;
            if (o_grant !== 4'b0010) begin
                errors++;
                $display("[TB] FAIL early_grant c%0d: got %b expected %b", c, o_grant, 4'b0010);
            end
        end
        i_req = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            @(negedge i_clk);
            if (o_busy === 1'b1) busy_count++;
            checks++;
            if (o_grant !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL early_release c%0d: got %b expected %b", c, o_grant, 4'b0000);
            end
        end
        checks++;
        if (busy_count !== 3) begin
            errors++;
            $display("[TB] FAIL early_busy_len: got %0d expected %0d", busy_count, 3);
        end
        i_req = 4'b1111;
        @(negedge i_clk);
        checks++;
        if (o_grant !== 4'b0100 || {o_sel_1, o_sel_2} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL early_next_grant: got grant %b sel %b expected grant 0100 sel 10",
                     o_grant, {o_sel_1, o_sel_2});
        end
    endtask

    task automatic test_data_gating();
        do_reset();
        i_req = 4'b1000;
        for (int c = 1; c <= 10; c++) begin
            logic exp_busy;
            logic exp_data;
            @(negedge i_clk);
            i_data   = c[0];
            exp_busy = (c <= 8);
            exp_data = exp_busy ? c[0] : 1'b0;
            #1;
            checks++;
            if (o_data !== exp_data || o_busy !== exp_busy) begin
                errors++;
                $display("[TB] FAIL gating c%0d: got data %b busy %b expected data %b busy %b",
                         c, o_data, o_busy, exp_data, exp_busy);
            end
            checks++;
            if ({o_sel_1, o_sel_2} !== 2'b11) begin
                errors++;
                $display("[TB] FAIL gating_sel c%0d: got %b expected %b", c, {o_sel_1, o_sel_2}, 2'b11);
            end
        end
        i_data = 1'b0;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        i_req  = 4'b1111;
        i_data = 1'b1;
        repeat (20) @(negedge i_clk);
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            checks++;
            if (o_grant !== 4'b0100) begin
                errors++;
                $display("[TB] FAIL midreset_pre c%0d: got %b expected %b", c, o_grant, 4'b0100);
            end
        end
        i_reset = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_grant !== 4'b0000 || o_busy !== 1'b0 || {o_sel_1, o_sel_2} !== 2'b00 || o_data !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got grant %b busy %b sel %b data %b expected all zero",
                     o_grant, o_busy, {o_sel_1, o_sel_2}, o_data);
        end
        i_reset = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_grant !== 4'b0001 || {o_sel_1, o_sel_2} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL midreset_first_grant: got grant %b sel %b expected grant 0001 sel 00",
                     o_grant, {o_sel_1, o_sel_2});
        end
        i_data = 1'b0;
    endtask

    task automatic test_slot_one();
        do_reset();
        i_req = 4'b0001;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                logic [3:0] exp_grant;
                exp_grant = (c == 0) ? 4'b0001 : 4'b0000;
                @(negedge i_clk);
                checks++;
                if (s1_grant !== exp_grant || s1_busy !== (c == 0)) begin
                    errors++;
                    $display("[TB] FAIL slot_one r%0d c%0d: got grant %b busy %b expected grant %b busy %b",
                             r, c, s1_grant, s1_busy, exp_grant, (c == 0));
                end
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        i_reset = 1'b1;
        i_req   = 4'b0000;
        i_data  = 1'b0;
        test_reset();
        test_single_held();
        test_all_held();
        test_early_release();
        test_data_gating();
        test_reset_mid_grant();
        test_slot_one();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
